// File: rtl/seg595_pkg.sv
// Shared types and constants for the 74HC595 multiplexed 7-segment scan driver.
package seg595_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, HOLD} state_e;

    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEL_NONE  = 8'hFF;

    // Segment pattern g..a (bit 6..0), active high, for one hex nibble.
    function automatic logic [6:0] hex_pattern(input logic [3:0] h);
        logic [6:0] p;
        case (h)
            4'h0: p = 7'h3F;
            4'h1: p = 7'h06;
            4'h2: p = 7'h5B;
            4'h3: p = 7'h4F;
            4'h4: p = 7'h66;
            4'h5: p = 7'h6D;
            4'h6: p = 7'h7D;
            4'h7: p = 7'h07;
            4'h8: p = 7'h7F;
            4'h9: p = 7'h6F;
            4'hA: p = 7'h77;
            4'hB: p = 7'h7C;
            4'hC: p = 7'h39;
            4'hD: p = 7'h5E;
            4'hE: p = 7'h79;
            default: p = 7'h71;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/seg595_if.sv
// Pin bundle toward the two-chip 74HC595 chain.
interface seg595_if;
    logic ser_data;
    logic ser_clk;
    logic ser_latch;
    logic ser_oe_n;

    modport master (output ser_data, ser_clk, ser_latch, ser_oe_n);
    modport slave  (input  ser_data, ser_clk, ser_latch, ser_oe_n);
endinterface

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble + decimal point to 7-segment byte {dp, g..a}.
module seg_hex_decode
    import seg595_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       dp,
    output logic [7:0] seg
);
    assign seg = {dp, hex_pattern(hex)};
endmodule

// File: rtl/seg595_scan_driver.sv
// Multiplexed 7-segment scan driver for a two-chip 74HC595 chain.
// Per digit: LOAD word, SHIFT 16 bits MSB first, LATCH, HOLD, next digit.
// Optional leading-zero blanking is enabled by defining SEG595_LZB_EN.
module seg595_scan_driver
    import seg595_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int CLK_DIV     = 2,
    parameter int HOLD_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    seg595_if.master              pins,
    output logic                  busy,
    output logic                  frame_done
);
    // One counter serves the ser_clk divider, the latch width and the hold time.
    localparam int CNT_MAX = (CLK_DIV > HOLD_CYCLES) ? CLK_DIV : HOLD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic [2:0]       IDX_LAST  = 3'(DIGITS - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                phase_q, phase_d;
    logic [3:0]          bit_q, bit_d;
    logic [15:0]         shreg_q, shreg_d;
    logic [2:0]          idx_q, idx_d;
    logic [4*DIGITS-1:0] snap_dig_q, snap_dig_d;
    logic [DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic                snap_en_q, snap_en_d;
    logic                ser_data_q, ser_data_d;
    logic                ser_clk_q, ser_clk_d;
    logic                ser_latch_q, ser_latch_d;
    logic                oe_n_q;
    logic                busy_q, busy_d;
    logic                fd_q, fd_d;

    logic [4*DIGITS-1:0] src_dig;
    logic [DIGITS-1:0]   src_dp;
    logic                src_en;
    logic [31:0]         dig_pad;
    logic [7:0]          dp_pad;
    logic [3:0]          cur_hex;
    logic                cur_dp;
    logic                blank;
    logic [7:0]          dec_seg, seg, sel_n;
    logic [15:0]         word;

    seg_hex_decode u_dec (.hex(cur_hex), .dp(cur_dp), .seg(dec_seg));

    // Word for the current digit; digit 0 reads live inputs since that LOAD takes the snapshot.
    always_comb begin
        src_dig = (idx_q == 3'd0) ? digits_in : snap_dig_q;
        src_dp  = (idx_q == 3'd0) ? dp_in     : snap_dp_q;
        src_en  = (idx_q == 3'd0) ? en        : snap_en_q;
        dig_pad = 32'(src_dig);
        dp_pad  = 8'(src_dp);
        cur_hex = dig_pad[{idx_q, 2'b00} +: 4];
        cur_dp  = dp_pad[idx_q];
`ifdef SEG595_LZB_EN
        // Blank when this digit and everything above it are zero.
        blank   = (idx_q != 3'd0) && ((dig_pad >> {idx_q, 2'b00}) == 32'd0);
`else
        blank   = 1'b0;
`endif
        seg     = blank ? {dec_seg[7], SEG_BLANK[6:0]} : dec_seg;
        sel_n   = ~(8'h01 << idx_q);
        word    = src_en ? {sel_n, seg} : {SEL_NONE, SEG_BLANK};
    end

    // Next-state logic; pin outputs are derived from next state so they leave flops aligned with state_q.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        idx_d      = idx_q;
        snap_dig_d = snap_dig_q;
        snap_dp_d  = snap_dp_q;
        snap_en_d  = snap_en_q;
        fd_d       = 1'b0;
        unique case (state_q)
            IDLE: state_d = LOAD;
            LOAD: begin
                shreg_d = word;
                cnt_d   = '0;
                phase_d = 1'b0;
                bit_d   = 4'd0;
                state_d = SHIFT;
                if (idx_q == 3'd0) begin
                    snap_dig_d = digits_in;
                    snap_dp_d  = dp_in;
                    snap_en_d  = en;
                end
            end
            SHIFT: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (bit_q == 4'd15) begin
                            state_d = LATCH;
                        end else begin
                            bit_d   = bit_q + 4'd1;
                            shreg_d = {shreg_q[14:0], 1'b0};
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LATCH: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    idx_d   = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
                    fd_d    = (idx_q == IDX_LAST);
                    state_d = (HOLD_CYCLES == 0) ? LOAD : HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = LOAD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        ser_clk_d   = (state_d == SHIFT) && phase_d;
        ser_data_d  = (state_d == SHIFT) && shreg_d[15];
        ser_latch_d = (state_d == LATCH);
        busy_d      = (state_d != IDLE);
    end

    // State and output registers; reset aborts any transfer in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            phase_q     <= 1'b0;
            bit_q       <= 4'd0;
            shreg_q     <= '0;
            idx_q       <= 3'd0;
            snap_dig_q  <= '0;
            snap_dp_q   <= '0;
            snap_en_q   <= 1'b0;
            ser_data_q  <= 1'b0;
            ser_clk_q   <= 1'b0;
            ser_latch_q <= 1'b0;
            oe_n_q      <= 1'b1;
            busy_q      <= 1'b0;
            fd_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            idx_q       <= idx_d;
            snap_dig_q  <= snap_dig_d;
            snap_dp_q   <= snap_dp_d;
            snap_en_q   <= snap_en_d;
            ser_data_q  <= ser_data_d;
            ser_clk_q   <= ser_clk_d;
            ser_latch_q <= ser_latch_d;
            oe_n_q      <= ~en;
            busy_q      <= busy_d;
            fd_q        <= fd_d;
        end
    end

    assign pins.ser_data  = ser_data_q;
    assign pins.ser_clk   = ser_clk_q;
    assign pins.ser_latch = ser_latch_q;
    assign pins.ser_oe_n  = oe_n_q;
    assign busy           = busy_q;
    assign frame_done     = fd_q;

endmodule
